mem_exception_ctrl: RTL and testbench

- Exception arbitration and flush controller in the MEM stage, directly upstream of the CP0 register file.
- Merges per-instruction exception flags with synchronized external interrupts and priority-encodes one exception type per cycle.
- Drives the CP0 exception inputs (type, PC, delay-slot flag, bad address) in the same cycle.
- Produces a registered one-cycle pipeline flush and redirect PC.

---
 rtl/mem_exception_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_exception_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_exception_ctrl.sv
// MEM-stage exception arbitration and pipeline flush controller.
// Merges per-instruction exception flags with synchronized external
// interrupts, priority-encodes one exception per cycle for CP0, and
// produces a registered one-cycle flush plus redirect PC.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   int_i[5:0]               asynchronous hardware interrupt lines
//   valid_i, pc_i            MEM instruction present / its PC
//   is_in_delayslot_i        MEM instruction sits in a delay slot
//   exc_*_i                  raw exception flags from earlier stages
//   mem_addr_i               load/store data address
//   cp0_status/cause/epc_i   current CP0 register values
//   wb_cp0_we/waddr/data_i   WB-stage CP0 write, forwarded here
//   excepttype_o             exception code to CP0, 0 = none (comb.)
//   current_inst_addr_o      pc_i passthrough
//   is_in_delayslot_o        delay-slot passthrough
//   bad_addr_o               faulting address, 0 when not applicable
//   mem_kill_o               suppress MEM-stage load/store side effects
//   flush_o, new_pc_o        registered flush pulse and redirect PC
module mem_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_syscall_i,
  input  logic        exc_break_i,
  input  logic        exc_ov_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_st_i,
  input  logic        exc_eret_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        mem_kill_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;

  // Interrupt synchronizer as one packed shift register; newest sample in
  // the low bits, synchronized value taken from the top stage.
  logic [SYNC_STAGES*6-1:0] sync_q;
  logic [5:0]               int_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES*6-7:0], int_i};
  end

  assign int_s = sync_q[SYNC_STAGES*6-1 -: 6];

  // CP0 values as they will be once the in-flight WB write lands.
  logic [31:0] status_f, cause_f, epc_f;

  always_comb begin
    status_f = cp0_status_i;
    cause_f  = cp0_cause_i;
    epc_f    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      unique case (wb_cp0_waddr_i)
        5'd12: status_f = wb_cp0_data_i;
        5'd13: begin
          cause_f[9:8]   = wb_cp0_data_i[9:8];
          cause_f[23:22] = wb_cp0_data_i[23:22];
        end
        5'd14: epc_f = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{status_f[31:16], status_f[7:2], cause_f[31:10], cause_f[7:0]};

  logic pending, int_take;
  assign pending  = ({int_s, cause_f[9:8]} & status_f[15:8]) != 8'h00;
  assign int_take = pending & status_f[0] & ~status_f[1] & valid_i;

  logic [31:0] exc_code, bad_addr;

  always_comb begin
    exc_code = '0;
    bad_addr = '0;
    if (valid_i && state == RUN) begin
      if (int_take)           exc_code = 32'h01;
      else if (exc_adel_if_i) begin exc_code = 32'h04; bad_addr = pc_i; end
      else if (exc_ri_i)      exc_code = 32'h0a;
      else if (exc_syscall_i) exc_code = 32'h08;
      else if (exc_break_i)   exc_code = 32'h09;
      else if (exc_ov_i)      exc_code = 32'h0c;
      else if (exc_adel_ld_i) begin exc_code = 32'h04; bad_addr = mem_addr_i; end
      else if (exc_ades_st_i) begin exc_code = 32'h05; bad_addr = mem_addr_i; end
      else if (exc_eret_i)    exc_code = 32'h0e;
    end
  end

  assign excepttype_o        = exc_code;
  assign bad_addr_o          = bad_addr;
  assign current_inst_addr_o = pc_i;
  assign is_in_delayslot_o   = is_in_delayslot_i;
  assign mem_kill_o          = (exc_code != '0) | (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      flush_o  <= 1'b0;
      new_pc_o <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (exc_code != '0) begin
            state    <= FLUSH;
            flush_o  <= 1'b1;
            new_pc_o <= (exc_code == 32'h0e) ? epc_f : EXC_VECTOR;
          end else begin
            flush_o <= 1'b0;
          end
        end
        FLUSH: begin
          state   <= RUN;
          flush_o <= 1'b0;
        end
        default: begin
          state   <= RUN;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_exception_ctrl.sv
// Scoreboard bench for mem_exception_ctrl: the driver pushes the expected
// per-cycle response from a behavioural model, a monitor pops and compares.
module tb_mem_exception_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam int          SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        valid_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_data_i;
  logic        exc_adel_if_i, exc_ri_i, exc_syscall_i, exc_break_i;
  logic        exc_ov_i, exc_adel_ld_i, exc_ades_st_i, exc_eret_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, mem_kill_o, flush_o;

  mem_exception_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .valid_i(valid_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i), .exc_syscall_i(exc_syscall_i),
    .exc_break_i(exc_break_i), .exc_ov_i(exc_ov_i), .exc_adel_ld_i(exc_adel_ld_i),
    .exc_ades_st_i(exc_ades_st_i), .exc_eret_i(exc_eret_i),
    .mem_addr_i(mem_addr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .mem_kill_o(mem_kill_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  // fl bit order: adel_if, ri, syscall, break, ov, adel_ld, ades_st, eret
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [7:0]  fl;
    logic [31:0] maddr, status, cause, epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  intr;
  } stim_t;

  typedef struct {
    logic [31:0] exc, bad, pc, newpc;
    logic        ds, kill, flush;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: whether the cycle is a flush cycle, last redirect PC,
  // and the int_i values driven in the last SYNC cycles (oldest first).
  logic       m_flush;
  logic [31:0] m_newpc;
  logic [5:0] m_ihist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] code_of(input int i);
    case (i)
      0: return 32'h04; 1: return 32'h0a; 2: return 32'h08; 3: return 32'h09;
      4: return 32'h0c; 5: return 32'h04; 6: return 32'h05; default: return 32'h0e;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.valid = 1'b0; s.pc = '0; s.ds = 1'b0; s.fl = '0; s.maddr = '0;
    s.status = '0; s.cause = '0; s.epc = '0; s.we = 1'b0; s.waddr = '0;
    s.wdata = '0; s.intr = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(0, 4) != 0);
    s.pc    = $urandom;
    s.ds    = $urandom_range(0, 1) == 1;
    for (int i = 0; i < 8; i++) s.fl[i] = ($urandom_range(0, 9) == 0);
    s.maddr  = $urandom;
    s.status = ($urandom_range(0, 1) == 1) ? 32'h0000FF01 : $urandom;
    s.cause  = $urandom;
    s.epc    = $urandom;
    s.we     = $urandom_range(0, 1) == 1;
    case ($urandom_range(0, 3))
      0: s.waddr = 5'd12;
      1: s.waddr = 5'd13;
      2: s.waddr = 5'd14;
      default: s.waddr = 5'($urandom);
    endcase
    s.wdata = $urandom;
    s.intr  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    valid_i = s.valid; pc_i = s.pc; is_in_delayslot_i = s.ds;
    exc_adel_if_i = s.fl[0]; exc_ri_i = s.fl[1]; exc_syscall_i = s.fl[2];
    exc_break_i = s.fl[3]; exc_ov_i = s.fl[4]; exc_adel_ld_i = s.fl[5];
    exc_ades_st_i = s.fl[6]; exc_eret_i = s.fl[7];
    mem_addr_i = s.maddr; cp0_status_i = s.status; cp0_cause_i = s.cause;
    cp0_epc_i = s.epc; wb_cp0_we_i = s.we; wb_cp0_waddr_i = s.waddr;
    wb_cp0_data_i = s.wdata; int_i = s.intr;
  endtask

  task automatic model_reset();
    m_flush = 1'b0;
    m_newpc = '0;
    m_ihist = {};
    for (int i = 0; i < SYNC; i++) m_ihist.push_back(6'h00);
  endtask

  // One clock cycle: drive inputs, predict the response, advance model.
  task automatic drive_cycle(input stim_t s);
    exp_t        e;
    logic [31:0] statf, epcf;
    logic [1:0]  cb;
    logic [5:0]  ints;
    logic        irq, found;
    @(posedge clk);
    #1;
    apply(s);
    statf = (s.we && s.waddr == 5'd12) ? s.wdata : s.status;
    cb    = (s.we && s.waddr == 5'd13) ? s.wdata[9:8] : s.cause[9:8];
    epcf  = (s.we && s.waddr == 5'd14) ? s.wdata : s.epc;
    ints  = m_ihist.pop_front();
    m_ihist.push_back(s.intr);
    irq = (({ints, cb} & statf[15:8]) != 8'h00) && statf[0] && !statf[1];
    e.exc = '0;
    e.bad = '0;
    if (s.valid && !m_flush) begin
      if (irq) e.exc = 32'h01;
      else begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (s.fl[i] && !found) begin
            found = 1'b1;
            e.exc = code_of(i);
            if (i == 0) e.bad = s.pc;
            else if (i == 5 || i == 6) e.bad = s.maddr;
          end
        end
      end
    end
    e.kill  = (e.exc != 0) || m_flush;
    e.flush = m_flush;
    e.newpc = m_newpc;
    e.pc    = s.pc;
    e.ds    = s.ds;
    sb.push_back(e);
    if (m_flush) m_flush = 1'b0;
    else if (e.exc != 0) begin
      m_flush = 1'b1;
      m_newpc = (e.exc == 32'h0e) ? epcf : VEC;
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("excepttype", excepttype_o, e.exc);
        chk("bad_addr", bad_addr_o, e.bad);
        chk("inst_addr", current_inst_addr_o, e.pc);
        chk("delayslot", 32'(is_in_delayslot_o), 32'(e.ds));
        chk("mem_kill", 32'(mem_kill_o), 32'(e.kill));
        chk("flush", 32'(flush_o), 32'(e.flush));
        chk("new_pc", new_pc_o, e.newpc);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    apply(idle());
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flush", 32'(flush_o), 32'h0);
    chk("reset_new_pc", new_pc_o, 32'h0);
    chk("reset_kill", 32'(mem_kill_o), 32'h0);
    rst = 1'b0;

    // syscall, then two idle cycles to observe flush pulse and its end
    s = idle(); s.valid = 1'b1; s.pc = 32'h80001000; s.fl[2] = 1'b1;
    drive_cycle(s);
    drive_cycle(idle());
    drive_cycle(idle());

    // store address error in a delay slot
    s = idle(); s.valid = 1'b1; s.pc = 32'h80001100; s.ds = 1'b1;
    s.maddr = 32'h80002003; s.fl[6] = 1'b1;
    drive_cycle(s);
    drive_cycle(idle());

    // interrupt line 2 rises; visible two cycles later, beats overflow
    s = idle(); s.valid = 1'b1; s.status = 32'h0000FF01; s.intr = 6'b000100;
    drive_cycle(s);
    drive_cycle(s);
    s.fl[4] = 1'b1;
    drive_cycle(s);
    s = idle(); s.intr = 6'b000100;
    drive_cycle(s);
    drive_cycle(idle());
    drive_cycle(idle());
    drive_cycle(idle());

    // ERET with EPC forwarded from WB
    s = idle(); s.valid = 1'b1; s.fl[7] = 1'b1; s.epc = 32'h12345678;
    s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'h80004000;
    drive_cycle(s);
    drive_cycle(idle());

    // break followed immediately by ri: second one masked by flush
    s = idle(); s.valid = 1'b1; s.pc = 32'h80003000; s.fl[3] = 1'b1;
    drive_cycle(s);
    s = idle(); s.valid = 1'b1; s.pc = 32'h80003004; s.fl[1] = 1'b1;
    drive_cycle(s);
    drive_cycle(idle());

    for (int n = 0; n < 2000; n++) drive_cycle(rand_stim());

    // asynchronous reset in the middle of a flush cycle
    drive_cycle(idle());
    s = idle(); s.valid = 1'b1; s.fl[2] = 1'b1;
    drive_cycle(s);
    @(posedge clk);
    #2;
    chk("pre_rst_flush", 32'(flush_o), 32'h1);
    apply(idle());
    rst = 1'b1;
    #1;
    chk("async_rst_flush", 32'(flush_o), 32'h0);
    chk("async_rst_new_pc", new_pc_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 500; n++) drive_cycle(rand_stim());
    drive_cycle(idle());

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
